reaction_ctrl: RTL

- Sequencing controller for the reaction-timer datapath: LFSR random delay, 8-bit down counter, 4-digit BCD counter.
- Arms a random delay, lights the stimulus LED, runs the BCD counter until the player responds, then freezes and reports the result.
- Flags false starts. Drives enable, clear and load strobes into the existing counters; sits between the top-level KEY/SW inputs and those counters.

---
 rtl/reaction_pkg.sv | 18 +
 rtl/reaction_ctrl_rise_detect.sv | 18 +
 rtl/reaction_ctrl.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/reaction_pkg.sv
// Shared types and default constants for the reaction-timer sequencing controller.
package reaction_pkg;

   localparam int unsigned BCD_WIDTH = 16;

   localparam logic [7:0]           MIN_DELAY_DEF   = 8'd16;
   localparam logic [BCD_WIDTH-1:0] TIMEOUT_BCD_DEF = 16'h9999;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ARM   = 3'd1,
      ST_WAIT  = 3'd2,
      ST_REACT = 3'd3,
      ST_DONE  = 3'd4,
      ST_FOUL  = 3'd5
   } state_t;

endpackage

// File: rtl/reaction_ctrl_rise_detect.sv
// 1-bit registered rising-edge detector; o_rise is high in the cycle the input first reads 1.
module rise_detect (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_d,
   output logic o_rise
);

   logic r_prev;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_prev <= 1'b0;
      else          r_prev <= i_d;
   end

   assign o_rise = i_d & ~r_prev;

endmodule

// File: rtl/reaction_ctrl.sv
// Reaction-timer sequencing controller: random delay, stimulus, BCD timing, foul detection.
// Optional best-time tracking is built when REACTION_BEST_TIME_EN is defined.
module reaction_ctrl
   import reaction_pkg::*;
#(
   parameter logic [7:0]           MIN_DELAY   = MIN_DELAY_DEF,
   parameter logic [BCD_WIDTH-1:0] TIMEOUT_BCD = TIMEOUT_BCD_DEF
) (
   input  logic                 MAX10_CLK1_50,
   input  logic                 RESET_n,
   input  logic                 start_btn,
   input  logic                 react_btn,
   input  logic [7:0]           lfsr_value,
   input  logic                 dly_done,
   input  logic [BCD_WIDTH-1:0] bcd_count,
   output logic                 dly_load,
   output logic [7:0]           dly_preset,
   output logic                 dly_en,
   output logic                 bcd_clr,
   output logic                 bcd_en,
   output logic                 stim_led,
   output logic                 false_start,
   output logic [BCD_WIDTH-1:0] result,
   output logic [2:0]           state
`ifdef REACTION_BEST_TIME_EN
  ,output logic [BCD_WIDTH-1:0] best_time,
   output logic                 new_best
`endif
);

   state_t               r_state;
   state_t               w_next;
   logic                 w_start_rise;
   logic                 w_react_rise;
   logic                 w_dly_load;
   logic                 w_dly_en;
   logic                 w_bcd_clr;
   logic                 w_bcd_en;
   logic                 w_stim;
   logic                 w_capture;
   logic                 w_timeout;
   logic [7:0]           r_preset;
   logic                 r_false_start;
   logic [BCD_WIDTH-1:0] r_result;

   rise_detect u_start_rise (
      .i_clk   (MAX10_CLK1_50),
      .i_rst_n (RESET_n),
      .i_d     (start_btn),
      .o_rise  (w_start_rise)
   );

   rise_detect u_react_rise (
      .i_clk   (MAX10_CLK1_50),
      .i_rst_n (RESET_n),
      .i_d     (react_btn),
      .o_rise  (w_react_rise)
   );

   always_ff @(posedge MAX10_CLK1_50 or negedge RESET_n) begin
      if (!RESET_n) r_state <= ST_IDLE;
      else          r_state <= w_next;
   end

   always_comb begin
      w_next     = r_state;
      w_dly_load = 1'b0;
      w_dly_en   = 1'b0;
      w_bcd_clr  = 1'b0;
      w_bcd_en   = 1'b0;
      w_stim     = 1'b0;
      w_capture  = 1'b0;
      w_timeout  = 1'b0;
      case (r_state)
         ST_IDLE: if (w_start_rise) w_next = ST_ARM;
         ST_ARM: begin
            w_dly_load = 1'b1;
            w_bcd_clr  = 1'b1;
            w_next     = ST_WAIT;
         end
         ST_WAIT: begin
            w_dly_en = 1'b1;
            if (w_react_rise)  w_next = ST_FOUL;
            else if (dly_done) w_next = ST_REACT;
         end
         ST_REACT: begin
            w_stim   = 1'b1;
            w_bcd_en = 1'b1;
            if (w_react_rise) begin
               w_next    = ST_DONE;
               w_capture = 1'b1;
            end else if (bcd_count == TIMEOUT_BCD) begin
               w_next    = ST_DONE;
               w_timeout = 1'b1;
            end
         end
         ST_DONE: if (w_start_rise) w_next = ST_ARM;
         ST_FOUL: if (w_start_rise) w_next = ST_ARM;
         default: w_next = ST_IDLE;
      endcase
   end

   // Preset and foul flag are latched on the transition into ARM/FOUL so they are
   // already valid while the Moore strobes for that state are high.
   always_ff @(posedge MAX10_CLK1_50 or negedge RESET_n) begin
      if (!RESET_n) begin
         r_preset      <= '0;
         r_false_start <= 1'b0;
         r_result      <= '0;
      end else begin
         if (w_next == ST_ARM) begin
            r_preset      <= (lfsr_value < MIN_DELAY) ? MIN_DELAY : lfsr_value;
            r_false_start <= 1'b0;
         end
         if (w_next == ST_FOUL && r_state == ST_WAIT) begin
            r_false_start <= 1'b1;
            r_result      <= '0;
         end
         if (w_capture)      r_result <= bcd_count;
         else if (w_timeout) r_result <= TIMEOUT_BCD;
      end
   end

`ifdef REACTION_BEST_TIME_EN
   logic [BCD_WIDTH-1:0] r_best_time;
   logic                 r_new_best;

   always_ff @(posedge MAX10_CLK1_50 or negedge RESET_n) begin
      if (!RESET_n) begin
         r_best_time <= 16'h9999;
         r_new_best  <= 1'b0;
      end else begin
         r_new_best <= 1'b0;
         if (w_capture && (bcd_count < r_best_time)) begin
            r_best_time <= bcd_count;
            r_new_best  <= 1'b1;
         end
      end
   end

   assign best_time = r_best_time;
   assign new_best  = r_new_best;
`endif

   assign dly_load    = w_dly_load;
   assign dly_en      = w_dly_en;
   assign bcd_clr     = w_bcd_clr;
   assign bcd_en      = w_bcd_en;
   assign stim_led    = w_stim;
   assign dly_preset  = r_preset;
   assign false_start = r_false_start;
   assign result      = r_result;
   assign state       = r_state;

endmodule
